// File: rtl/rv32_pkg.sv
// Shared pipeline types and constants for the rv32 forwarding/hazard logic.
// Holds register-address type, bypass select encodings and the arch register count.
// No logic here; consumers import rv32_pkg::*.
package rv32_pkg;

   localparam int NUM_ARCH_REGS = 32;

   // Bypass select code meaning "take the operand from the register file".
   localparam int FWD_RF = 0;

   typedef logic [4:0] reg_addr_t;

   // Select code for the long-latency writeback bus: one past the last stage code.
   function automatic int fwd_wb_code(input int num_fwd);
      return num_fwd + 1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency writers: busy vector, outstanding count, sticky error.
// Latency: set/clear visible after the next clk_i edge; wb_clear_o/full_o are combinational.
// Backpressure: none internally; the parent stalls issue via full_o and busy_o.
//
// Ports: issue_i/issue_rd_i mark a new long op; wb_valid_i/wb_rd_i retire one.
// busy_o/outstanding_o/err_o are registered; wb_clear_o flags a writeback that retires a busy entry.
module hazard_scoreboard
   import rv32_pkg::*;
#(
   parameter int MAX_OUT = 4,
   parameter int CNTW    = $clog2(MAX_OUT + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     issue_i,
   input  reg_addr_t                issue_rd_i,
   input  logic                     wb_valid_i,
   input  reg_addr_t                wb_rd_i,
   output logic [NUM_ARCH_REGS-1:0] busy_o,
   output logic [CNTW-1:0]          outstanding_o,
   output logic                     wb_clear_o,
   output logic                     full_o,
   output logic                     err_o
);

   logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
   logic [CNTW-1:0]          cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     wb_spurious;

   // A writeback only retires an entry if that register is actually tracked.
   assign wb_clear_o  = wb_valid_i && (wb_rd_i != '0) && busy_q[wb_rd_i];
   assign wb_spurious = wb_valid_i && (wb_rd_i != '0) && !busy_q[wb_rd_i];
   assign full_o      = (cnt_q == CNTW'(MAX_OUT));

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      err_d  = err_q || wb_spurious;

      // Clear before set: a same-cycle retire and reissue of one register leaves it busy.
      if (wb_clear_o) begin
         busy_d[wb_rd_i] = 1'b0;
      end
      if (issue_i) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;

      case ({issue_i, wb_clear_o})
         2'b10:   cnt_d = cnt_q + CNTW'(1);
         2'b01:   cnt_d = cnt_q - CNTW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_o        = busy_q;
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass selection and ID/IF stall generation for N read ports over K bypass stages.
// Latency: fwd_sel_o/stall_o combinational (zero cycles); scoreboard state updates next clk_i edge.
// Backpressure: stall_o holds ID/IF on not-ready producers, busy sources, WAW or a full scoreboard.
//
// Ports: ID side (id_valid_i, rs_addr_i, rs_used_i, id_rd_i, id_long_i, flush_i);
// bypass stages (fwd_rd_i, fwd_we_i, fwd_ready_i, index 0 youngest); long writeback (wb_valid_i, wb_rd_i);
// outputs fwd_sel_o (0 rf, k+1 stage k, NUM_FWD+1 wb bus), stall_o, sb_busy_o, outstanding_o, sb_err_o.
module fwd_hazard_unit
   import rv32_pkg::*;
#(
   parameter int NUM_RS  = 2,
   parameter int NUM_FWD = 2,
   parameter int MAX_OUT = 4,
   parameter int SELW    = $clog2(NUM_FWD + 2)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                id_valid_i,
   input  logic [NUM_RS-1:0][4:0]              rs_addr_i,
   input  logic [NUM_RS-1:0]                   rs_used_i,
   input  logic [4:0]                          id_rd_i,
   input  logic                                id_long_i,
   input  logic                                flush_i,
   input  logic [NUM_FWD-1:0][4:0]             fwd_rd_i,
   input  logic [NUM_FWD-1:0]                  fwd_we_i,
   input  logic [NUM_FWD-1:0]                  fwd_ready_i,
   input  logic                                wb_valid_i,
   input  logic [4:0]                          wb_rd_i,
   output logic [NUM_RS-1:0][SELW-1:0]         fwd_sel_o,
   output logic                                stall_o,
   output logic [NUM_ARCH_REGS-1:0]            sb_busy_o,
   output logic [$clog2(MAX_OUT+1)-1:0]        outstanding_o,
   output logic                                sb_err_o
);

   localparam int CNTW    = $clog2(MAX_OUT + 1);
   localparam int WB_CODE = fwd_wb_code(NUM_FWD);

   logic [NUM_ARCH_REGS-1:0] busy;
   logic                     wb_clear;
   logic                     sb_full;
   logic                     issue;

   logic [NUM_RS-1:0] port_hit;
   logic [NUM_RS-1:0] port_rdy;
   logic [NUM_RS-1:0] notready_haz;
   logic [NUM_RS-1:0] raw_haz;
   logic              waw_haz;
   logic              full_haz;
   logic              any_haz;

   // Per-port priority bypass. Scanning oldest to youngest lets the youngest
   // match overwrite, so an older ready result never hides a younger not-ready one.
   always_comb begin
      fwd_sel_o    = '0;
      port_hit     = '0;
      port_rdy     = '0;
      notready_haz = '0;
      raw_haz      = '0;
      for (int p = 0; p < NUM_RS; p++) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (rs_used_i[p] && fwd_we_i[k] && (fwd_rd_i[k] == rs_addr_i[p]) &&
                (rs_addr_i[p] != '0)) begin
               port_hit[p]  = 1'b1;
               port_rdy[p]  = fwd_ready_i[k];
               fwd_sel_o[p] = SELW'(k + 1);
            end
         end
         if (!port_hit[p]) begin
            if (wb_valid_i && (wb_rd_i == rs_addr_i[p]) && (rs_addr_i[p] != '0)) begin
               fwd_sel_o[p] = SELW'(WB_CODE);
            end else begin
               fwd_sel_o[p] = SELW'(FWD_RF);
            end
         end
         notready_haz[p] = port_hit[p] && !port_rdy[p];
         // busy[0] is never set, so x0 cannot raise this; a same-cycle writeback releases it.
         raw_haz[p] = rs_used_i[p] && busy[rs_addr_i[p]] &&
                      !(wb_valid_i && (wb_rd_i == rs_addr_i[p]));
      end
   end

   assign waw_haz  = id_long_i && (id_rd_i != '0) && busy[id_rd_i] &&
                     !(wb_valid_i && (wb_rd_i == id_rd_i));
   // A retiring writeback frees a slot in the same cycle, so a full scoreboard can still accept.
   assign full_haz = id_long_i && sb_full && !wb_clear;
   assign any_haz  = (|notready_haz) || (|raw_haz) || waw_haz || full_haz;

   assign stall_o  = id_valid_i && !flush_i && any_haz;
   assign issue    = id_valid_i && id_long_i && (id_rd_i != '0) && !stall_o && !flush_i;

   hazard_scoreboard #(
      .MAX_OUT (MAX_OUT),
      .CNTW    (CNTW)
   ) u_scoreboard (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .issue_i       (issue),
      .issue_rd_i    (id_rd_i),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_i       (wb_rd_i),
      .busy_o        (busy),
      .outstanding_o (outstanding_o),
      .wb_clear_o    (wb_clear),
      .full_o        (sb_full),
      .err_o         (sb_err_o)
   );

   assign sb_busy_o = busy;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (NUM_RS=2, NUM_FWD=2, MAX_OUT=4).
// Expected values are queued as each step is driven and drained against the DUT outputs.
// Combinational outputs are checked 1 ns after driving; registered ones 1 ns after the clock edge.
module tb_fwd_hazard_unit;

   localparam int NUM_RS  = 2;
   localparam int NUM_FWD = 2;
   localparam int MAX_OUT = 4;
   localparam int SELW    = $clog2(NUM_FWD + 2);

   localparam int K_SEL0  = 0;
   localparam int K_SEL1  = 1;
   localparam int K_STALL = 2;
   localparam int K_BUSY  = 3;
   localparam int K_OUT   = 4;
   localparam int K_ERR   = 5;

   logic                        clk_i = 1'b0;
   logic                        rst_ni;
   logic                        id_valid;
   logic [NUM_RS-1:0][4:0]      rs_addr;
   logic [NUM_RS-1:0]           rs_used;
   logic [4:0]                  id_rd;
   logic                        id_long;
   logic                        flush;
   logic [NUM_FWD-1:0][4:0]     fwd_rd;
   logic [NUM_FWD-1:0]          fwd_we;
   logic [NUM_FWD-1:0]          fwd_ready;
   logic                        wb_valid;
   logic [4:0]                  wb_rd;
   logic [NUM_RS-1:0][SELW-1:0] fwd_sel;
   logic                        stall;
   logic [31:0]                 sb_busy;
   logic [$clog2(MAX_OUT+1)-1:0] outstanding;
   logic                        sb_err;

   typedef struct {
      int          kind;
      logic [63:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk_i = ~clk_i;

   fwd_hazard_unit #(
      .NUM_RS  (NUM_RS),
      .NUM_FWD (NUM_FWD),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .id_valid_i    (id_valid),
      .rs_addr_i     (rs_addr),
      .rs_used_i     (rs_used),
      .id_rd_i       (id_rd),
      .id_long_i     (id_long),
      .flush_i       (flush),
      .fwd_rd_i      (fwd_rd),
      .fwd_we_i      (fwd_we),
      .fwd_ready_i   (fwd_ready),
      .wb_valid_i    (wb_valid),
      .wb_rd_i       (wb_rd),
      .fwd_sel_o     (fwd_sel),
      .stall_o       (stall),
      .sb_busy_o     (sb_busy),
      .outstanding_o (outstanding),
      .sb_err_o      (sb_err)
   );

   function automatic logic [63:0] obs(input int kind);
      case (kind)
         K_SEL0:  return 64'(fwd_sel[0]);
         K_SEL1:  return 64'(fwd_sel[1]);
         K_STALL: return 64'(stall);
         K_BUSY:  return 64'(sb_busy);
         K_OUT:   return 64'(outstanding);
         default: return 64'(sb_err);
      endcase
   endfunction

   task automatic want(input int kind, input logic [63:0] val, input string tag);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [63:0] got;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = obs(e.kind);
         n_cmp++;
         assert (got === e.val) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, got, e.val);
         end
      end
   endtask

   task automatic clear_in();
      id_valid  = 1'b0;
      rs_addr   = '0;
      rs_used   = '0;
      id_rd     = '0;
      id_long   = 1'b0;
      flush     = 1'b0;
      fwd_rd    = '0;
      fwd_we    = '0;
      fwd_ready = '0;
      wb_valid  = 1'b0;
      wb_rd     = '0;
   endtask

   task automatic comb_check();
      #1;
      drain();
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      drain();
   endtask

   task automatic want_state(input logic [31:0] b, input int o, input logic e, input string tag);
      want(K_BUSY, 64'(b), {tag, "_busy"});
      want(K_OUT,  64'(o), {tag, "_out"});
      want(K_ERR,  64'(e), {tag, "_err"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in();
      rst_ni = 1'b0;
      #12;
      want_state(32'h0, 0, 1'b0, "reset");
      want(K_SEL0,  0, "reset_sel0");
      want(K_STALL, 0, "reset_stall");
      drain();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Both stages write x5: youngest (EX) wins.
      clear_in();
      id_valid = 1'b1; rs_addr[0] = 5; rs_used = 2'b01;
      fwd_rd[0] = 5; fwd_rd[1] = 5; fwd_we = 2'b11; fwd_ready = 2'b11;
      want(K_SEL0, 1, "x5_ex_sel0");
      want(K_SEL1, 0, "x5_unused_sel1");
      want(K_STALL, 0, "x5_ex_stall");
      comb_check();

      // Only MEM writes x5, both ports read it.
      fwd_we = 2'b10; rs_addr[1] = 5; rs_used = 2'b11;
      want(K_SEL0, 2, "x5_mem_sel0");
      want(K_SEL1, 2, "x5_mem_sel1");
      want(K_STALL, 0, "x5_mem_stall");
      comb_check();

      // Load-use: EX load to x7 not ready.
      clear_in();
      id_valid = 1'b1; rs_addr[1] = 7; rs_used = 2'b10;
      fwd_rd[0] = 7; fwd_we = 2'b01; fwd_ready = 2'b00;
      want(K_SEL1, 1, "lu_ex_sel1");
      want(K_STALL, 1, "lu_ex_stall");
      comb_check();
      tick();

      // Load now in MEM and ready.
      clear_in();
      id_valid = 1'b1; rs_addr[1] = 7; rs_used = 2'b10;
      fwd_rd[1] = 7; fwd_we = 2'b10; fwd_ready = 2'b10;
      want(K_SEL1, 2, "lu_mem_sel1");
      want(K_STALL, 0, "lu_mem_stall");
      comb_check();

      // Older ready stage must not bypass past a younger not-ready match.
      fwd_rd[0] = 7; fwd_we = 2'b11; fwd_ready = 2'b10;
      want(K_SEL1, 1, "shadow_sel1");
      want(K_STALL, 1, "shadow_stall");
      comb_check();

      // Issue long op to x9.
      clear_in();
      id_valid = 1'b1; id_long = 1'b1; id_rd = 9;
      want(K_STALL, 0, "long9_stall");
      comb_check();
      want_state(32'h200, 1, 1'b0, "long9");
      tick();

      // Consumer of x9 stalls while busy.
      clear_in();
      id_valid = 1'b1; rs_addr[0] = 9; rs_used = 2'b01;
      want(K_SEL0, 0, "raw9_sel0");
      want(K_STALL, 1, "raw9_stall");
      comb_check();
      want_state(32'h200, 1, 1'b0, "raw9_hold");
      tick();

      // Writeback of x9 releases the stall and bypasses from the wb bus.
      wb_valid = 1'b1; wb_rd = 9;
      want(K_SEL0, 3, "wb9_sel0");
      want(K_STALL, 0, "wb9_stall");
      comb_check();
      want_state(32'h0, 0, 1'b0, "wb9");
      tick();

      // Fill the scoreboard with x1..x4.
      for (int r = 1; r <= 4; r++) begin
         clear_in();
         id_valid = 1'b1; id_long = 1'b1; id_rd = 5'(r);
         want(K_STALL, 0, $sformatf("fill%0d_stall", r));
         comb_check();
         tick();
      end
      want(K_OUT, 4, "fill_out");
      want(K_BUSY, 64'h1E, "fill_busy");
      drain();

      // Fifth long op stalls on full.
      clear_in();
      id_valid = 1'b1; id_long = 1'b1; id_rd = 5;
      want(K_STALL, 1, "full_stall");
      comb_check();
      want_state(32'h1E, 4, 1'b0, "full_hold");
      tick();

      // Fifth issues together with the x1 writeback.
      wb_valid = 1'b1; wb_rd = 1;
      want(K_STALL, 0, "full_wb_stall");
      comb_check();
      want_state(32'h3C, 4, 1'b0, "full_wb");
      tick();

      // WAW on x3 stalls; flush in the same cycle kills it without issuing.
      clear_in();
      id_valid = 1'b1; id_long = 1'b1; id_rd = 3;
      want(K_STALL, 1, "waw_stall");
      comb_check();
      flush = 1'b1;
      want(K_STALL, 0, "waw_flush_stall");
      comb_check();
      want_state(32'h3C, 4, 1'b0, "waw_flush");
      tick();

      // x3 writeback arriving releases WAW in the same cycle; reissue keeps x3 busy.
      flush = 1'b0; wb_valid = 1'b1; wb_rd = 3;
      want(K_STALL, 0, "waw_wb_stall");
      comb_check();
      want_state(32'h3C, 4, 1'b0, "waw_wb");
      tick();

      // x0 never matches; spurious writeback to x12 sets the error flag.
      clear_in();
      id_valid = 1'b1; rs_addr[0] = 0; rs_addr[1] = 12; rs_used = 2'b11;
      fwd_rd[0] = 0; fwd_we = 2'b01; fwd_ready = 2'b01;
      wb_valid = 1'b1; wb_rd = 12;
      want(K_SEL0, 0, "x0_sel0");
      want(K_SEL1, 3, "x12_sel1");
      want(K_STALL, 0, "x12_stall");
      comb_check();
      want_state(32'h3C, 4, 1'b1, "spurious12");
      tick();

      // Asynchronous reset mid-run, checked before any clock edge.
      clear_in();
      rst_ni = 1'b0;
      #1;
      want_state(32'h0, 0, 1'b0, "async_rst");
      drain();
      rst_ni = 1'b1;

      // Late writeback of a pre-reset op is spurious.
      wb_valid = 1'b1; wb_rd = 4;
      want_state(32'h0, 0, 1'b1, "late_wb");
      tick();

      clear_in();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
